// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment capture block:
// active-low segment codes for hex digits 0..F, the all-off pattern, and parameter defaults.
package seg_pkg;

  localparam int NDIG_DEF   = 4;
  localparam int STABLE_DEF = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Indexed by the hex value each pattern represents.
  localparam logic [6:0] SEG_CODES [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] value;
  } seg_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder from an active-low 7-segment pattern to {legal, is_blank, value}.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  always_comb begin
    // NOTE: default every field first so no path leaves o_dec unassigned (no latch).
    o_dec          = '0;
    o_dec.is_blank = (i_seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_CODES[i]) begin
        o_dec.legal = 1'b1;
        o_dec.value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed 7-segment display into per-digit hex values with stability filtering.
// Optional feature: define SEG_CAPTURE_ERRCNT_EN to add the saturating 8-bit err_cnt output.
module seg_capture
  import seg_pkg::*;
#(
  parameter int NDIG   = NDIG_DEF,
  parameter int STABLE = STABLE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_en,
  input  logic              sample_vld,
  output logic [4*NDIG-1:0] hex_out,
  output logic [NDIG-1:0]   dig_valid,
  output logic [NDIG-1:0]   blank,
  output logic              upd,
`ifdef SEG_CAPTURE_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              err
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [6:0] r_cand [NDIG];
  logic [3:0] r_cnt  [NDIG];

  logic            w_accept;
  logic            w_bad_sample;
  logic [NDIG-1:0] w_match;
  logic [3:0]      w_next_cnt [NDIG];
  logic [NDIG-1:0] w_commit;
  logic            w_commit_any;
  logic            w_err_set;
  seg_dec_t        w_dec;

  seg7_to_hex u_dec (
    .i_seg (seg_in),
    .o_dec (w_dec)
  );

  assign w_accept     = sample_vld &  $onehot(dig_en);
  assign w_bad_sample = sample_vld & ~$onehot(dig_en);

  // Commit only on the transition into STABLE; a saturated repeat keeps the count without firing.
  always_comb begin
    for (int d = 0; d < NDIG; d++) begin
      w_match[d]    = (seg_in == r_cand[d]);
      w_next_cnt[d] = 4'd1;
      if (w_match[d])
        w_next_cnt[d] = (r_cnt[d] == STABLE_C) ? r_cnt[d] : r_cnt[d] + 4'd1;
      w_commit[d] = w_accept & dig_en[d] & (w_next_cnt[d] == STABLE_C) &
                    (~w_match[d] | (r_cnt[d] != STABLE_C));
    end
  end

  assign w_commit_any = |w_commit;
  assign w_err_set    = w_bad_sample | (w_commit_any & ~w_dec.legal & ~w_dec.is_blank);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out   <= '0;
      dig_valid <= '0;
      blank     <= '1;
      upd       <= 1'b0;
      err       <= 1'b0;
      // NOTE: the candidate/count arrays are architectural state, so they are reset explicitly.
      for (int d = 0; d < NDIG; d++) begin
        r_cand[d] <= SEG_BLANK;
        r_cnt[d]  <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      upd <= w_commit_any;
      err <= w_err_set;
      for (int d = 0; d < NDIG; d++) begin
        if (w_accept && dig_en[d]) begin
          r_cand[d] <= seg_in;
          r_cnt[d]  <= w_next_cnt[d];
        end
        if (w_commit[d]) begin
          if (w_dec.legal) begin
            hex_out[4*d +: 4] <= w_dec.value;
            dig_valid[d]      <= 1'b1;
            blank[d]          <= 1'b0;
          end else begin
            dig_valid[d] <= 1'b0;
            blank[d]     <= w_dec.is_blank;
          end
        end
      end
    end
  end

`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_err_set && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed, table-driven bench for seg_capture (NDIG=4, STABLE=3); honours SEG_CAPTURE_ERRCNT_EN.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic        sample_vld;
  logic [15:0] hex_out;
  logic [3:0]  dig_valid;
  logic [3:0]  blank;
  logic        upd;
  logic        err;
`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  seg_capture #(.NDIG(4), .STABLE(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
    .sample_vld (sample_vld),
    .hex_out    (hex_out),
    .dig_valid  (dig_valid),
    .blank      (blank),
    .upd        (upd),
`ifdef SEG_CAPTURE_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  en;
    logic [6:0]  seg;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  blk;
    logic        upd;
    logic        err;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic vld, input logic [3:0] en, input logic [6:0] seg,
                              input logic [15:0] hex, input logic [3:0] valid,
                              input logic [3:0] blk, input logic u, input logic e,
                              input logic [7:0] ecnt);
    vec_t v;
    v.vld = vld; v.en = en; v.seg = seg; v.hex = hex; v.valid = valid;
    v.blk = blk; v.upd = u; v.err = e; v.ecnt = ecnt;
    vecs.push_back(v);
  endfunction

  // Present one sample across a rising edge, then settle before sampling outputs.
  task automatic step(input logic vld, input logic [3:0] en, input logic [6:0] seg);
    sample_vld = vld;
    dig_en     = en;
    seg_in     = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] hex, input logic [3:0] valid,
                           input logic [3:0] blk, input logic u, input logic e,
                           input logic [7:0] ecnt);
    check({tag, ".hex"},   32'(hex_out),   32'(hex));
    check({tag, ".valid"}, 32'(dig_valid), 32'(valid));
    check({tag, ".blank"}, 32'(blank),     32'(blk));
    check({tag, ".upd"},   32'(upd),       32'(u));
    check({tag, ".err"},   32'(err),       32'(e));
`ifdef SEG_CAPTURE_ERRCNT_EN
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ecnt));
`else
    if (ecnt == 8'hFF) $display("unexpected error-count tag %s", tag);
`endif
  endtask

  logic [6:0] codes [16];

  initial begin
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    //   vld en       seg    hex       valid    blank    upd   err   ecnt
    // three 30h on digit 0 -> commit 3
    add(1, 4'b0001, 7'h30, 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);
    add(1, 4'b0001, 7'h30, 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);
    add(1, 4'b0001, 7'h30, 16'h0003, 4'b0001, 4'b1110, 1, 0, 8'd0);
    add(0, 4'b0001, 7'h30, 16'h0003, 4'b0001, 4'b1110, 0, 0, 8'd0);
    // digit 1: 2x 12h, then 02h restarts; 2 more 02h commit 6
    add(1, 4'b0010, 7'h12, 16'h0003, 4'b0001, 4'b1110, 0, 0, 8'd0);
    add(1, 4'b0010, 7'h12, 16'h0003, 4'b0001, 4'b1110, 0, 0, 8'd0);
    add(1, 4'b0010, 7'h02, 16'h0003, 4'b0001, 4'b1110, 0, 0, 8'd0);
    add(1, 4'b0010, 7'h02, 16'h0003, 4'b0001, 4'b1110, 0, 0, 8'd0);
    add(1, 4'b0010, 7'h02, 16'h0063, 4'b0011, 4'b1100, 1, 0, 8'd0);
    add(0, 4'b0010, 7'h02, 16'h0063, 4'b0011, 4'b1100, 0, 0, 8'd0);
    // digit 2: commit d, then blank it with 7Fh
    add(1, 4'b0100, 7'h21, 16'h0063, 4'b0011, 4'b1100, 0, 0, 8'd0);
    add(1, 4'b0100, 7'h21, 16'h0063, 4'b0011, 4'b1100, 0, 0, 8'd0);
    add(1, 4'b0100, 7'h21, 16'h0D63, 4'b0111, 4'b1000, 1, 0, 8'd0);
    add(1, 4'b0100, 7'h7F, 16'h0D63, 4'b0111, 4'b1000, 0, 0, 8'd0);
    add(1, 4'b0100, 7'h7F, 16'h0D63, 4'b0111, 4'b1000, 0, 0, 8'd0);
    add(1, 4'b0100, 7'h7F, 16'h0D63, 4'b0011, 4'b1100, 1, 0, 8'd0);
    add(0, 4'b0100, 7'h7F, 16'h0D63, 4'b0011, 4'b1100, 0, 0, 8'd0);
    // illegal pattern 55h on digit 0, then a two-hot select
    add(1, 4'b0001, 7'h55, 16'h0D63, 4'b0011, 4'b1100, 0, 0, 8'd0);
    add(1, 4'b0001, 7'h55, 16'h0D63, 4'b0011, 4'b1100, 0, 0, 8'd0);
    add(1, 4'b0001, 7'h55, 16'h0D63, 4'b0010, 4'b1100, 1, 1, 8'd1);
    add(1, 4'b0011, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 1, 8'd2);
    add(0, 4'b0011, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 0, 8'd2);
    // interleaved digits 3 and 0 commit on back-to-back cycles; saturated repeat is silent
    add(1, 4'b1000, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 0, 8'd2);
    add(1, 4'b1000, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 0, 8'd2);
    add(1, 4'b0001, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 0, 8'd2);
    add(1, 4'b0001, 7'h40, 16'h0D63, 4'b0010, 4'b1100, 0, 0, 8'd2);
    add(1, 4'b1000, 7'h40, 16'h0D63, 4'b1010, 4'b0100, 1, 0, 8'd2);
    add(1, 4'b0001, 7'h40, 16'h0D60, 4'b1011, 4'b0100, 1, 0, 8'd2);
    add(1, 4'b0001, 7'h40, 16'h0D60, 4'b1011, 4'b0100, 0, 0, 8'd2);
    add(0, 4'b0001, 7'h40, 16'h0D60, 4'b1011, 4'b0100, 0, 0, 8'd2);
    // zero-hot select with sample_vld is dropped and flagged
    add(1, 4'b0000, 7'h40, 16'h0D60, 4'b1011, 4'b0100, 0, 1, 8'd3);
    add(0, 4'b0000, 7'h40, 16'h0D60, 4'b1011, 4'b0100, 0, 0, 8'd3);

    rst_n = 1'b0;
    step(0, 4'b0000, 7'h7F);
    step(0, 4'b0000, 7'h7F);
    rst_n = 1'b1;
    check_all("reset", 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].en, vecs[i].seg);
      check_all($sformatf("vec%0d", i), vecs[i].hex, vecs[i].valid, vecs[i].blk,
                vecs[i].upd, vecs[i].err, vecs[i].ecnt);
    end

    // Reset mid-count: the sample in the reset cycle and the partial count are both lost.
    step(1, 4'b0001, 7'h30);
    step(1, 4'b0001, 7'h30);
    rst_n = 1'b0;
    step(1, 4'b0001, 7'h30);
    rst_n = 1'b1;
    check_all("rst_in_reset", 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);
    step(1, 4'b0001, 7'h30);
    check_all("rst_after1", 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);
    step(1, 4'b0001, 7'h30);
    check_all("rst_after2", 16'h0000, 4'b0000, 4'b1111, 0, 0, 8'd0);
    step(1, 4'b0001, 7'h30);
    check_all("rst_after3", 16'h0003, 4'b0001, 4'b1110, 1, 0, 8'd0);

    // Every legal code on digit 1; digit 0 must stay at 3.
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 3; k++) step(1, 4'b0010, codes[c]);
      check($sformatf("sweep%0d.hex", c), 32'(hex_out), 32'({8'h00, 4'(c), 4'h3}));
      check($sformatf("sweep%0d.valid", c), 32'(dig_valid), 32'(4'b0011));
      check($sformatf("sweep%0d.upd", c), 32'(upd), 32'd1);
      check($sformatf("sweep%0d.err", c), 32'(err), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
